// File: rtl/multi_cycle_ctrl.sv
// rtl/multi_cycle_ctrl.sv - multi-cycle CPU control unit (IF/ID/EXE/MEM/WB sequencer)
//
// Purpose: sequences each instruction through the multi-cycle states and
// decodes state + opcode into datapath write enables and mux selects.
// Outputs are combinational from state, op and zero; while Reset is low
// every output is forced to 0.
//
// Optional feature macro: CTRL_INSTR_CNT_EN
//   defined   -> instr_count counts cycles where PCWre=1 (wraps, cleared by Reset)
//   undefined -> instr_count is tied to 0, no counter flops
//
// Ports:
//   CLK         in   system clock, posedge
//   Reset       in   asynchronous active-low reset
//   op[5:0]     in   opcode from instruction register
//   zero        in   ALU result == 0
//   sign        in   ALU result[31] (not needed by this decode)
//   PCWre       out  PC write enable
//   IRWre       out  instruction register load enable
//   InsMemRW    out  instruction memory read
//   RegWre      out  register file write enable
//   ALUSrcA     out  0: rs, 1: zero-extended Sa
//   ALUSrcB     out  0: rt, 1: extended immediate
//   ExtSel      out  0: zero-extend, 1: sign-extend
//   RegDst[1:0] out  00: $31, 01: rt, 10: rd
//   WrRegDSrc   out  0: PC+4, 1: DB bus
//   DBDataSrc   out  0: ALU result, 1: data memory
//   mRD         out  data memory read
//   mWR         out  data memory write
//   PCSrc[1:0]  out  00: PC+4, 01: branch, 10: jr, 11: jump target
//   ALUOp[2:0]  out  ALU operation
//   state[2:0]  out  current state code
//   instr_count out  retired-instruction counter

module multi_cycle_ctrl (
  input  logic        CLK,
  input  logic        Reset,
  input  logic [5:0]  op,
  input  logic        zero,
  input  logic        sign,
  output logic        PCWre,
  output logic        IRWre,
  output logic        InsMemRW,
  output logic        RegWre,
  output logic        ALUSrcA,
  output logic        ALUSrcB,
  output logic        ExtSel,
  output logic [1:0]  RegDst,
  output logic        WrRegDSrc,
  output logic        DBDataSrc,
  output logic        mRD,
  output logic        mWR,
  output logic [1:0]  PCSrc,
  output logic [2:0]  ALUOp,
  output logic [2:0]  state,
  output logic [31:0] instr_count
);

  typedef enum logic [2:0] {
    S_IF     = 3'b000,
    S_ID     = 3'b001,
    S_EXE_LS = 3'b010,
    S_MEM    = 3'b011,
    S_WB_LD  = 3'b100,
    S_EXE_BR = 3'b101,
    S_EXE_AL = 3'b110,
    S_WB_AL  = 3'b111
  } state_t;

  localparam logic [5:0] OP_ADD   = 6'b000000;
  localparam logic [5:0] OP_SUB   = 6'b000001;
  localparam logic [5:0] OP_ADDIU = 6'b000010;
  localparam logic [5:0] OP_AND   = 6'b010000;
  localparam logic [5:0] OP_ANDI  = 6'b010001;
  localparam logic [5:0] OP_ORI   = 6'b010010;
  localparam logic [5:0] OP_SLT   = 6'b100110;
  localparam logic [5:0] OP_SLL   = 6'b011000;
  localparam logic [5:0] OP_SW    = 6'b110000;
  localparam logic [5:0] OP_LW    = 6'b110001;
  localparam logic [5:0] OP_BEQ   = 6'b110100;
  localparam logic [5:0] OP_BNE   = 6'b110101;
  localparam logic [5:0] OP_J     = 6'b111000;
  localparam logic [5:0] OP_JR    = 6'b111001;
  localparam logic [5:0] OP_JAL   = 6'b111010;
  localparam logic [5:0] OP_HALT  = 6'b111111;

  state_t cur;

  // The ALU sign flag is not consumed by this control decode.
  logic unused_sign;
  assign unused_sign = sign;

  logic is_add, is_sub, is_addiu, is_and, is_andi, is_ori, is_slt, is_sll;
  logic is_sw, is_lw, is_beq, is_bne, is_j, is_jr, is_jal, is_halt;
  logic is_rtype, is_alu, is_nop;

  assign is_add   = (op == OP_ADD);
  assign is_sub   = (op == OP_SUB);
  assign is_addiu = (op == OP_ADDIU);
  assign is_and   = (op == OP_AND);
  assign is_andi  = (op == OP_ANDI);
  assign is_ori   = (op == OP_ORI);
  assign is_slt   = (op == OP_SLT);
  assign is_sll   = (op == OP_SLL);
  assign is_sw    = (op == OP_SW);
  assign is_lw    = (op == OP_LW);
  assign is_beq   = (op == OP_BEQ);
  assign is_bne   = (op == OP_BNE);
  assign is_j     = (op == OP_J);
  assign is_jr    = (op == OP_JR);
  assign is_jal   = (op == OP_JAL);
  assign is_halt  = (op == OP_HALT);

  assign is_rtype = is_add | is_sub | is_and | is_slt | is_sll;
  assign is_alu   = is_rtype | is_addiu | is_andi | is_ori;
  // Anything not recognised retires as a 2-cycle NOP.
  assign is_nop   = ~(is_alu | is_sw | is_lw | is_beq | is_bne |
                      is_j | is_jr | is_jal | is_halt);

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      cur <= S_IF;
    end else begin
      unique case (cur)
        S_IF: cur <= S_ID;
        S_ID: begin
          if (is_beq | is_bne)    cur <= S_EXE_BR;
          else if (is_lw | is_sw) cur <= S_EXE_LS;
          else if (is_alu)        cur <= S_EXE_AL;
          else                    cur <= S_IF;   // j/jr/jal/halt/NOP
        end
        S_EXE_LS: cur <= S_MEM;
        S_MEM:    cur <= is_lw ? S_WB_LD : S_IF;
        S_WB_LD:  cur <= S_IF;
        S_EXE_BR: cur <= S_IF;
        S_EXE_AL: cur <= S_WB_AL;
        S_WB_AL:  cur <= S_IF;
        default:  cur <= S_IF;
      endcase
    end
  end

  always_comb begin
    PCWre     = 1'b0;
    IRWre     = 1'b0;
    InsMemRW  = 1'b0;
    RegWre    = 1'b0;
    ALUSrcA   = 1'b0;
    ALUSrcB   = 1'b0;
    ExtSel    = 1'b0;
    RegDst    = 2'b00;
    WrRegDSrc = 1'b0;
    DBDataSrc = 1'b0;
    mRD       = 1'b0;
    mWR       = 1'b0;
    PCSrc     = 2'b00;
    ALUOp     = 3'b000;
    state     = 3'b000;
    // Gating on Reset makes an abort drop every enable in the same cycle,
    // without waiting for the asynchronous state clear to propagate.
    if (Reset) begin
      state    = cur;
      InsMemRW = 1'b1;
      IRWre    = (cur == S_IF);

      // PCWre marks the last cycle of each instruction; halt never retires.
      PCWre = ((cur == S_ID) & (is_j | is_jr | is_jal | is_nop)) |
              (cur == S_EXE_BR) |
              ((cur == S_MEM) & is_sw) |
              (cur == S_WB_LD) |
              (cur == S_WB_AL);

      RegWre = (cur == S_WB_AL) | (cur == S_WB_LD) | ((cur == S_ID) & is_jal);

      mRD = ((cur == S_MEM) & is_lw) | (cur == S_WB_LD);
      mWR = (cur == S_MEM) & is_sw;

      WrRegDSrc = ~is_jal;
      DBDataSrc = is_lw;
      ALUSrcA   = is_sll;
      ALUSrcB   = is_addiu | is_andi | is_ori | is_lw | is_sw;
      ExtSel    = ~(is_andi | is_ori);

      if (is_rtype)
        RegDst = 2'b10;
      else if (is_addiu | is_andi | is_ori | is_lw)
        RegDst = 2'b01;
      else
        RegDst = 2'b00;

      if ((is_beq & zero) | (is_bne & ~zero))
        PCSrc = 2'b01;
      else if (is_jr)
        PCSrc = 2'b10;
      else if (is_j | is_jal)
        PCSrc = 2'b11;
      else
        PCSrc = 2'b00;

      if (is_beq | is_bne | is_sub)
        ALUOp = 3'b001;
      else if (is_slt)
        ALUOp = 3'b101;
      else if (is_sll)
        ALUOp = 3'b010;
      else if (is_ori)
        ALUOp = 3'b011;
      else if (is_and | is_andi)
        ALUOp = 3'b100;
      else
        ALUOp = 3'b000;
    end
  end

`ifdef CTRL_INSTR_CNT_EN
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset)
      instr_count <= 32'd0;
    else if (PCWre)
      instr_count <= instr_count + 32'd1;
  end
`else
  assign instr_count = 32'd0;
`endif

endmodule
